keyboard_matrix: RTL and testbench
==================================

# keyboard_matrix

Wishbone responder and PIA-side server for the PET keyboard matrix. The management MCU, via the SPI-to-Wishbone bridge, writes the 10 row bytes of key state into this block at the keyboard Wishbone window. The emulated 6502 selects a row through PIA1 port A and reads the column bits through PIA1 port B. The block owns the PIA1 port/control registers needed for the keyboard path.

## Interface
Parameters:
- ROW_COUNT, 10, number of keyboard rows.
- DATA_WIDTH, 8, data width of rows, Wishbone and CPU data.
- ADDR_WIDTH, 4, Wishbone row-index width; equals bit width of ROW_COUNT-1.

Ports:
- clk_i  in  1  system clock (64 MHz).
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- wb_adr_i  in  ADDR_WIDTH  row index; the upstream decoder has already matched the keyboard base.
- wb_dat_i  in  DATA_WIDTH  write data, active-low columns (0 = key down).
- wb_dat_o  out  DATA_WIDTH  read data.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- wb_stall_o  out  1  stall; tied 0.
- pia_cs_i  in  1  CPU access to PIA1 this bus phase.
- pia_rs_i  in  2  register select: 0 PORTA, 1 CRA, 2 PORTB, 3 CRB.
- cpu_we_i  in  1  CPU write (1) / read (0).
- cpu_wr_strobe_i  in  1  one-cycle pulse marking the CPU write commit point.
- cpu_data_i  in  DATA_WIDTH  CPU write data.
- cpu_data_o  out  DATA_WIDTH  CPU read data.
- cpu_data_oe_o  out  1  drive enable for cpu_data_o.

## Operation
- State: row[0..ROW_COUNT-1] (8 b each), ORA, DDRA, CRA, ORB, DDRB, CRB.
- Wishbone, classic pipelined, no stall:
  - A beat is accepted when cyc&stb.
  - Write: row[adr] <= dat_i when adr < ROW_COUNT. Otherwise the write is dropped but still acked.
  - Read: wb_dat_o <= row[adr], or 8'hFF when adr >= ROW_COUNT.
  - Every accepted beat returns exactly one ack.
- PIA register writes (pia_cs_i & cpu_we_i & cpu_wr_strobe_i):
  - RS0: CRA[2]=1 writes ORA; CRA[2]=0 writes DDRA.
  - RS1: CRA <= {2'b00, data[5:0]}.
  - RS2: CRB[2]=1 writes ORB; CRB[2]=0 writes DDRB.
  - RS3: CRB <= {2'b00, data[5:0]}.
- PIA register reads (pia_cs_i & !cpu_we_i):
  - RS0: CRA[2] ? ORA : DDRA.
  - RS1: CRA (bits 7:6 always 0; no IRQ flags).
  - RS2: CRB[2] ? ((sel & ~DDRB) | (ORB & DDRB)) : DDRB, where sel = row[ORA[3:0]], or 8'hFF when ORA[3:0] >= ROW_COUNT.
  - RS3: CRB.
- Row selection uses ORA[3:0] regardless of DDRA. Row data is active-low; the reset value of each row is 8'hFF (no keys down).
- Collision: a Wishbone write to row r and a CPU port-B read of row r in the same cycle return the old row value to the CPU. The new value is visible from the next cycle.

## Timing
- Reset (rst_n_i low, asynchronous):
  - All rows = 8'hFF.
  - ORA, DDRA, CRA, ORB, DDRB, CRB = 0.
  - wb_ack_o = 0, wb_dat_o = 0, cpu_data_o = 0, cpu_data_oe_o = 0.
  - An in-flight Wishbone beat is lost with no ack; the initiator must restart it.
- wb_ack_o is a registered 1-cycle pulse, the cycle after acceptance. Back-to-back beats give back-to-back acks. wb_dat_o is valid with ack.
- An ack is suppressed if cyc drops in the acceptance cycle. No ack is generated without cyc.
- CPU read: cpu_data_o and cpu_data_oe_o are registered, valid 1 cycle after pia_cs_i & !cpu_we_i is first seen. They hold while that condition persists and cpu_data_oe_o drops 1 cycle after it ends.
- CPU write: the register updates on the clock edge where cpu_wr_strobe_i is high. The new value is visible to a read starting the next cycle.
- cpu_wr_strobe_i without pia_cs_i has no effect.

## Test plan
- Reset then PIA reads: CRA=1 with ORA=0, read RS2 with CRB=0 -> 8'h00 (DDRB). Set CRB=8'h04, read RS2 -> 8'hFF (row 0 idle).
- Wishbone write row 3 = 8'hFB, then CPU: CRA=8'h04, ORA=8'h03, CRB=8'h04, read RS2 -> 8'hFB, data valid one cycle after cs.
- Out-of-range: WB write adr 12 -> acked, no row changes. WB read adr 12 -> 8'hFF. ORA=8'h0A, port B read -> 8'hFF.
- Back-to-back WB writes to rows 0..9 with continuous stb -> 10 consecutive acks. Read back all rows -> data matches.
- DDRB mix: DDRB=8'hF0, ORB=8'h50, row 2 = 8'h0F, ORA=2 -> port B read 8'h5F.
- Collision and reset: WB write row 1 = 8'h00 in the same cycle as a CPU port-B read of row 1 (old value 8'hFF) -> CPU gets 8'hFF, next read 8'h00. Then assert rst_n_i mid-WB-beat -> no ack, rows = 8'hFF.

Source files
------------

// File: rtl/keyboard_matrix.sv
// PET keyboard matrix: Wishbone-writable row store plus the PIA1 port/control registers
// the emulated CPU uses to scan it.
module keyboard_matrix #(
    parameter int unsigned ROW_COUNT  = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic                  wb_ack_o,
    output logic                  wb_stall_o,

    input  logic                  pia_cs_i,
    input  logic [1:0]            pia_rs_i,
    input  logic                  cpu_we_i,
    input  logic                  cpu_wr_strobe_i,
    input  logic [DATA_WIDTH-1:0] cpu_data_i,
    output logic [DATA_WIDTH-1:0] cpu_data_o,
    output logic                  cpu_data_oe_o
);

    localparam logic [ADDR_WIDTH-1:0] WbRowLimit  = ADDR_WIDTH'(ROW_COUNT);
    localparam logic [3:0]            OraRowLimit = 4'(ROW_COUNT);

    logic [DATA_WIDTH-1:0] rows_q [ROW_COUNT];
    logic [DATA_WIDTH-1:0] rows_d [ROW_COUNT];

    logic [DATA_WIDTH-1:0] ora_q, ora_d, ddra_q, ddra_d, cra_q, cra_d;
    logic [DATA_WIDTH-1:0] orb_q, orb_d, ddrb_q, ddrb_d, crb_q, crb_d;

    logic                  wb_ack_q, wb_ack_d;
    logic [DATA_WIDTH-1:0] wb_dat_q, wb_dat_d;
    logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
    logic                  cpu_oe_q, cpu_oe_d;

    logic                  wb_acc;
    logic                  wb_in_range;
    logic [DATA_WIDTH-1:0] wb_rdata;
    logic                  cpu_wr;
    logic                  cpu_rd;
    logic [DATA_WIDTH-1:0] row_sel;
    logic [DATA_WIDTH-1:0] rd_val;

    assign wb_acc      = wb_cyc_i & wb_stb_i;
    assign wb_in_range = wb_adr_i < WbRowLimit;
    assign cpu_wr      = pia_cs_i & cpu_we_i & cpu_wr_strobe_i;
    assign cpu_rd      = pia_cs_i & ~cpu_we_i;

    // Wishbone side: row store update and registered response
    always_comb begin
        rows_d   = rows_q;
        wb_dat_d = wb_dat_q;
        wb_ack_d = wb_acc;
        wb_rdata = wb_in_range ? rows_q[wb_adr_i] : '1;
        if (wb_acc && wb_we_i && wb_in_range) begin
            rows_d[wb_adr_i] = wb_dat_i;
        end
        if (wb_acc && !wb_we_i) begin
            wb_dat_d = wb_rdata;
        end
    end

    // CPU register writes; CRx[2] steers the data-register address between OR and DDR
    always_comb begin
        ora_d  = ora_q;
        ddra_d = ddra_q;
        cra_d  = cra_q;
        orb_d  = orb_q;
        ddrb_d = ddrb_q;
        crb_d  = crb_q;
        if (cpu_wr) begin
            unique case (pia_rs_i)
                2'd0: begin
                    if (cra_q[2]) ora_d = cpu_data_i;
                    else          ddra_d = cpu_data_i;
                end
                2'd1: cra_d = {2'b00, cpu_data_i[5:0]};
                2'd2: begin
                    if (crb_q[2]) orb_d = cpu_data_i;
                    else          ddrb_d = cpu_data_i;
                end
                default: crb_d = {2'b00, cpu_data_i[5:0]};
            endcase
        end
    end

    // Port B reads rows_q, so a same-cycle Wishbone write is seen one cycle later
    always_comb begin
        row_sel = (ora_q[3:0] < OraRowLimit) ? rows_q[ora_q[3:0]] : '1;
        unique case (pia_rs_i)
            2'd0:    rd_val = cra_q[2] ? ora_q : ddra_q;
            2'd1:    rd_val = cra_q;
            2'd2:    rd_val = crb_q[2] ? ((row_sel & ~ddrb_q) | (orb_q & ddrb_q)) : ddrb_q;
            default: rd_val = crb_q;
        endcase
        cpu_oe_d   = cpu_rd;
        cpu_data_d = cpu_rd ? rd_val : cpu_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ROW_COUNT; i++) begin
                rows_q[i] <= '1;
            end
            ora_q      <= '0;
            ddra_q     <= '0;
            cra_q      <= '0;
            orb_q      <= '0;
            ddrb_q     <= '0;
            crb_q      <= '0;
            wb_ack_q   <= 1'b0;
            wb_dat_q   <= '0;
            cpu_data_q <= '0;
            cpu_oe_q   <= 1'b0;
        end else begin
            rows_q     <= rows_d;
            ora_q      <= ora_d;
            ddra_q     <= ddra_d;
            cra_q      <= cra_d;
            orb_q      <= orb_d;
            ddrb_q     <= ddrb_d;
            crb_q      <= crb_d;
            wb_ack_q   <= wb_ack_d;
            wb_dat_q   <= wb_dat_d;
            cpu_data_q <= cpu_data_d;
            cpu_oe_q   <= cpu_oe_d;
        end
    end

    assign wb_ack_o      = wb_ack_q;
    assign wb_dat_o      = wb_dat_q;
    assign wb_stall_o    = 1'b0;
    assign cpu_data_o    = cpu_data_q;
    assign cpu_data_oe_o = cpu_oe_q;

endmodule

// File: tb/tb_keyboard_matrix.sv
// Directed bench for keyboard_matrix: Wishbone row access, PIA1 register paths,
// out-of-range rows, DDRB mixing, write/read collision and mid-beat reset.
module tb_keyboard_matrix;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] wb_adr = '0;
    logic [7:0] wb_dat_in = '0;
    logic [7:0] wb_dat_out;
    logic       wb_we = 1'b0;
    logic       wb_cyc = 1'b0;
    logic       wb_stb = 1'b0;
    logic       wb_ack;
    logic       wb_stall;
    logic       pia_cs = 1'b0;
    logic [1:0] pia_rs = '0;
    logic       cpu_we = 1'b0;
    logic       cpu_strobe = 1'b0;
    logic [7:0] cpu_din = '0;
    logic [7:0] cpu_dout;
    logic       cpu_oe;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] row_exp [10];

    always #5 clk = ~clk;

    keyboard_matrix dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .wb_adr_i       (wb_adr),
        .wb_dat_i       (wb_dat_in),
        .wb_dat_o       (wb_dat_out),
        .wb_we_i        (wb_we),
        .wb_cyc_i       (wb_cyc),
        .wb_stb_i       (wb_stb),
        .wb_ack_o       (wb_ack),
        .wb_stall_o     (wb_stall),
        .pia_cs_i       (pia_cs),
        .pia_rs_i       (pia_rs),
        .cpu_we_i       (cpu_we),
        .cpu_wr_strobe_i(cpu_strobe),
        .cpu_data_i     (cpu_din),
        .cpu_data_o     (cpu_dout),
        .cpu_data_oe_o  (cpu_oe)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] rs, input logic [7:0] d);
        pia_cs = 1'b1; cpu_we = 1'b1; cpu_strobe = 1'b1; pia_rs = rs; cpu_din = d;
        tick();
        pia_cs = 1'b0; cpu_we = 1'b0; cpu_strobe = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [1:0] rs, input logic [7:0] exp);
        pia_cs = 1'b1; cpu_we = 1'b0; pia_rs = rs;
        tick();
        check({tag, "_oe"}, {7'd0, cpu_oe}, 8'h01);
        check(tag, cpu_dout, exp);
        pia_cs = 1'b0;
        tick();
        check({tag, "_oe_drop"}, {7'd0, cpu_oe}, 8'h00);
    endtask

    task automatic wb_write(input string tag, input logic [3:0] a, input logic [7:0] d);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = a; wb_dat_in = d;
        tick();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check({tag, "_ack"}, {7'd0, wb_ack}, 8'h01);
        tick();
        check({tag, "_ack_pulse"}, {7'd0, wb_ack}, 8'h00);
    endtask

    task automatic wb_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = a;
        tick();
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check({tag, "_ack"}, {7'd0, wb_ack}, 8'h01);
        check(tag, wb_dat_out, exp);
        tick();
    endtask

    initial begin
        #12;
        check("rst_ack", {7'd0, wb_ack}, 8'h00);
        check("rst_wb_dat", wb_dat_out, 8'h00);
        check("rst_cpu_data", cpu_dout, 8'h00);
        check("rst_cpu_oe", {7'd0, cpu_oe}, 8'h00);
        check("rst_stall", {7'd0, wb_stall}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // CRA=1 writes DDRA path; RS2 with CRB=0 returns DDRB
        cpu_write(2'd1, 8'h01);
        cpu_read("rs2_ddrb", 2'd2, 8'h00);
        cpu_write(2'd3, 8'h04);
        cpu_read("rs2_row0_idle", 2'd2, 8'hFF);
        cpu_read("rs0_ddra", 2'd0, 8'h00);

        // Row 3 key down via Wishbone, scanned by CPU
        wb_write("wb_w_row3", 4'd3, 8'hFB);
        cpu_write(2'd1, 8'h04);
        cpu_write(2'd0, 8'h03);
        cpu_read("rs0_ora", 2'd0, 8'h03);
        cpu_read("rs1_cra", 2'd1, 8'h04);
        cpu_read("rs2_row3", 2'd2, 8'hFB);

        // CR writes force bits 7:6 low; strobe without cs is ignored
        cpu_write(2'd3, 8'hC4);
        cpu_read("rs3_crb_mask", 2'd3, 8'h04);
        pia_cs = 1'b0; cpu_we = 1'b1; cpu_strobe = 1'b1; pia_rs = 2'd1; cpu_din = 8'h3F;
        tick();
        cpu_we = 1'b0; cpu_strobe = 1'b0;
        cpu_read("no_cs_write", 2'd1, 8'h04);

        // Out-of-range Wishbone and row select
        wb_write("wb_w_oor", 4'd12, 8'h00);
        wb_read("wb_r_oor", 4'd12, 8'hFF);
        wb_read("wb_r_row3_kept", 4'd3, 8'hFB);
        wb_read("wb_r_row9_kept", 4'd9, 8'hFF);
        cpu_write(2'd0, 8'h0A);
        cpu_read("rs2_oor_row", 2'd2, 8'hFF);

        // Back-to-back writes to all rows, then back-to-back reads
        for (int i = 0; i < 10; i++) row_exp[i] = 8'h10 + 8'(i * 7);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wb_adr = 4'(i); wb_dat_in = row_exp[i];
            tick();
            check($sformatf("b2b_w_ack%0d", i), {7'd0, wb_ack}, 8'h01);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tick();
        check("b2b_w_ack_end", {7'd0, wb_ack}, 8'h00);
        wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wb_adr = 4'(i);
            tick();
            check($sformatf("b2b_r_ack%0d", i), {7'd0, wb_ack}, 8'h01);
            check($sformatf("b2b_r_dat%0d", i), wb_dat_out, row_exp[i]);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick();

        // stb without cyc produces no ack
        wb_stb = 1'b1;
        tick();
        wb_stb = 1'b0;
        check("stb_no_cyc", {7'd0, wb_ack}, 8'h00);

        // DDRB mix: (0F & ~F0) | (50 & F0) = 5F
        cpu_write(2'd3, 8'h00);
        cpu_write(2'd2, 8'hF0);
        cpu_write(2'd3, 8'h04);
        cpu_write(2'd2, 8'h50);
        wb_write("wb_w_row2", 4'd2, 8'h0F);
        cpu_write(2'd0, 8'h02);
        cpu_read("ddrb_mix", 2'd2, 8'h5F);

        // Collision on row 1: CPU sees old value, then new
        cpu_write(2'd3, 8'h00);
        cpu_write(2'd2, 8'h00);
        cpu_write(2'd3, 8'h04);
        wb_write("wb_w_row1_idle", 4'd1, 8'hFF);
        cpu_write(2'd0, 8'h01);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 4'd1; wb_dat_in = 8'h00;
        pia_cs = 1'b1; cpu_we = 1'b0; pia_rs = 2'd2;
        tick();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check("coll_ack", {7'd0, wb_ack}, 8'h01);
        check("coll_old", cpu_dout, 8'hFF);
        tick();
        check("coll_new", cpu_dout, 8'h00);
        check("coll_oe_hold", {7'd0, cpu_oe}, 8'h01);
        pia_cs = 1'b0;
        tick();

        // Reset mid-beat: no ack, rows and registers cleared
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 4'd5; wb_dat_in = 8'h00;
        #2 rst_n = 1'b0;
        tick();
        check("rst_mid_ack", {7'd0, wb_ack}, 8'h00);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst2_ack", {7'd0, wb_ack}, 8'h00);
        wb_read("rst2_row1", 4'd1, 8'hFF);
        wb_read("rst2_row5", 4'd5, 8'hFF);
        cpu_read("rst2_cra", 2'd1, 8'h00);
        cpu_read("rst2_ddrb", 2'd2, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
